// File: rtl/debounce_pkg.sv
// ---------------------------------------------------------------------------
// debounce_pkg
// Shared constants and helpers for the multi-channel button debouncer.
//   DEF_*      : default parameter values used by multi_debouncer
//   cnt_width(): bit width needed to hold a counter's maximum value
// ---------------------------------------------------------------------------
package debounce_pkg;

    localparam int DEF_CHANNELS        = 4;
    localparam int DEF_DEBOUNCE_CYCLES = 250000;
    localparam int DEF_LONG_CYCLES     = 25000000;
    localparam int DEF_REPEAT_CYCLES   = 5000000;

    localparam int MAX_CHANNELS        = 32;

    // Width of a counter whose largest value is max_val. Never below one bit,
    // so degenerate parameters still elaborate to legal vectors.
    function automatic int cnt_width(input int max_val);
        if (max_val < 2)
            return 1;
        return $clog2(max_val + 1);
    endfunction

endpackage

// File: rtl/debounce_channel.sv
// ---------------------------------------------------------------------------
// debounce_channel
// One button channel: two-flop synchroniser, stability counter, debounced
// level, press/release pulses, long-press detection and (optionally)
// auto-repeat.
//
// Optional feature: define DEBOUNCER_REPEAT_EN to build the auto-repeat
// counter. Without it o_repeat is tied low and no repeat logic exists.
//
// Ports
//   clk        : rising-edge clock
//   rst        : synchronous active-high reset
//   i_btn      : raw asynchronous button level, 1 = pressed
//   o_state    : debounced level
//   o_pressed  : one-cycle pulse when o_state goes 0->1
//   o_released : one-cycle pulse when o_state goes 1->0
//   o_long     : one-cycle pulse once per press after LONG_CYCLES of hold
//   o_repeat   : one-cycle auto-repeat pulses after o_long
// ---------------------------------------------------------------------------
module debounce_channel
    import debounce_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
    parameter int LONG_CYCLES     = DEF_LONG_CYCLES,
    parameter int REPEAT_CYCLES   = DEF_REPEAT_CYCLES
) (
    input  logic clk,
    input  logic rst,
    input  logic i_btn,
    output logic o_state,
    output logic o_pressed,
    output logic o_released,
    output logic o_long,
    output logic o_repeat
);

    localparam int DB_W   = cnt_width(DEBOUNCE_CYCLES - 1);
    localparam int HOLD_W = cnt_width(LONG_CYCLES - 1);

    localparam logic [DB_W-1:0]   DB_LAST   = DB_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(LONG_CYCLES - 1);

    logic              r_sync1;
    logic              r_sync2;
    logic [DB_W-1:0]   r_db_cnt;
    logic              r_state;
    logic              r_pressed;
    logic              r_released;
    logic [HOLD_W-1:0] r_hold_cnt;
    logic              r_long_done;
    logic              r_long;

    logic w_differ;
    logic w_accept;
    logic w_long_hit;

    // The stability counter only advances while the synchronised level
    // disagrees with the accepted level; it is cleared on the accepting edge,
    // so it never exceeds DB_LAST.
    assign w_differ   = (r_sync2 != r_state);
    assign w_accept   = w_differ && (r_db_cnt == DB_LAST);
    assign w_long_hit = r_state && !r_long_done && (r_hold_cnt == HOLD_LAST);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_sync1    <= 1'b0;
            r_sync2    <= 1'b0;
            r_db_cnt   <= '0;
            r_state    <= 1'b0;
            r_pressed  <= 1'b0;
            r_released <= 1'b0;
        end else begin
            r_sync1 <= i_btn;
            r_sync2 <= r_sync1;

            if (!w_differ || w_accept)
                r_db_cnt <= '0;
            else
                r_db_cnt <= r_db_cnt + 1'b1;

            if (w_accept)
                r_state <= ~r_state;

            // Pulses are registered alongside the toggle so they appear in
            // the same cycle the new level does.
            r_pressed  <= w_accept && !r_state;
            r_released <= w_accept &&  r_state;
        end
    end

    // Hold counter stops at HOLD_LAST; r_long_done marks that this press has
    // already produced its long event.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_hold_cnt  <= '0;
            r_long_done <= 1'b0;
            r_long      <= 1'b0;
        end else begin
            r_long <= w_long_hit;
            if (!r_state) begin
                r_hold_cnt  <= '0;
                r_long_done <= 1'b0;
            end else if (w_long_hit) begin
                r_long_done <= 1'b1;
            end else if (!r_long_done) begin
                r_hold_cnt <= r_hold_cnt + 1'b1;
            end
        end
    end

`ifdef DEBOUNCER_REPEAT_EN
    localparam int REP_W = cnt_width(REPEAT_CYCLES - 1);
    localparam logic [REP_W-1:0] REP_LAST = REP_W'(REPEAT_CYCLES - 1);

    logic [REP_W-1:0] r_rep_cnt;
    logic             r_repeat;

    // Starts counting in the cycle btn_long appears, so the first repeat
    // lands REPEAT_CYCLES after it and then every REPEAT_CYCLES.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_rep_cnt <= '0;
            r_repeat  <= 1'b0;
        end else if (!r_state || !r_long_done) begin
            r_rep_cnt <= '0;
            r_repeat  <= 1'b0;
        end else if (r_rep_cnt == REP_LAST) begin
            r_rep_cnt <= '0;
            r_repeat  <= 1'b1;
        end else begin
            r_rep_cnt <= r_rep_cnt + 1'b1;
            r_repeat  <= 1'b0;
        end
    end

    assign o_repeat = r_repeat;
`else
    assign o_repeat = 1'b0;
`endif

    assign o_state    = r_state;
    assign o_pressed  = r_pressed;
    assign o_released = r_released;
    assign o_long     = r_long;

endmodule

// File: rtl/multi_debouncer.sv
// ---------------------------------------------------------------------------
// multi_debouncer
// CHANNELS independent button debouncers with press/release edge pulses,
// long-press detection and optional auto-repeat.
//
// Optional feature: define DEBOUNCER_REPEAT_EN to enable auto-repeat on
// btn_repeat; otherwise btn_repeat is constant 0.
//
// Ports
//   clk          : rising-edge clock
//   rst          : synchronous active-high reset
//   btn_in       : raw button levels, 1 = pressed
//   btn_state    : debounced levels
//   btn_pressed  : one-cycle pulse per accepted 0->1
//   btn_released : one-cycle pulse per accepted 1->0
//   btn_long     : one-cycle pulse once per press at LONG_CYCLES of hold
//   btn_repeat   : one-cycle auto-repeat pulses
// ---------------------------------------------------------------------------
module multi_debouncer
    import debounce_pkg::*;
#(
    parameter int CHANNELS        = DEF_CHANNELS,
    parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
    parameter int LONG_CYCLES     = DEF_LONG_CYCLES,
    parameter int REPEAT_CYCLES   = DEF_REPEAT_CYCLES
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [CHANNELS-1:0] btn_in,
    output logic [CHANNELS-1:0] btn_state,
    output logic [CHANNELS-1:0] btn_pressed,
    output logic [CHANNELS-1:0] btn_released,
    output logic [CHANNELS-1:0] btn_long,
    output logic [CHANNELS-1:0] btn_repeat
);

    if (CHANNELS < 1 || CHANNELS > MAX_CHANNELS ||
        DEBOUNCE_CYCLES < 2 || LONG_CYCLES <= DEBOUNCE_CYCLES ||
        REPEAT_CYCLES < 2) begin : g_bad_params
        $error("multi_debouncer: illegal parameter combination");
    end

    for (genvar g = 0; g < CHANNELS; g++) begin : g_ch
        debounce_channel #(
            .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
            .LONG_CYCLES     (LONG_CYCLES),
            .REPEAT_CYCLES   (REPEAT_CYCLES)
        ) u_ch (
            .clk        (clk),
            .rst        (rst),
            .i_btn      (btn_in[g]),
            .o_state    (btn_state[g]),
            .o_pressed  (btn_pressed[g]),
            .o_released (btn_released[g]),
            .o_long     (btn_long[g]),
            .o_repeat   (btn_repeat[g])
        );
    end

endmodule

// File: tb/tb_multi_debouncer.sv
// ---------------------------------------------------------------------------
// tb_multi_debouncer
// Directed scenarios with literal expectations, then randomized bouncy
// stimulus, all checked every cycle against a behavioural model built from
// input history windows and press run lengths.
// ---------------------------------------------------------------------------
module tb_multi_debouncer;

    localparam int CH   = 4;
    localparam int D    = 8;
    localparam int L    = 32;
    localparam int R    = 8;
    localparam int MAXE = 8000;

`ifdef DEBOUNCER_REPEAT_EN
    localparam logic REP_ON = 1'b1;
`else
    localparam logic REP_ON = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          rst;
    logic [CH-1:0] btn_in;
    logic [CH-1:0] btn_state, btn_pressed, btn_released, btn_long, btn_repeat;

    multi_debouncer #(
        .CHANNELS        (CH),
        .DEBOUNCE_CYCLES (D),
        .LONG_CYCLES     (L),
        .REPEAT_CYCLES   (R)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .btn_in       (btn_in),
        .btn_state    (btn_state),
        .btn_pressed  (btn_pressed),
        .btn_released (btn_released),
        .btn_long     (btn_long),
        .btn_repeat   (btn_repeat)
    );

    always #5 clk = ~clk;

    int n_chk  = 0;
    int n_fail = 0;
    int e      = 0;

    // Model: raw level sampled at every edge, accepted level, pulses, and
    // the length of the current run of accepted-pressed cycles.
    logic [CH-1:0] hist [0:MAXE-1];
    logic [CH-1:0] m_state, m_pr, m_rl, m_lg, m_rp;
    int            run [CH];

    task automatic check(input string name, input logic [CH-1:0] act,
                         input logic [CH-1:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %b expected %b (edge %0d)", name, act, exp, e);
        end
    endtask

    // Literal expectation applied to both the DUT and the model.
    task automatic lit(input string name, input logic [CH-1:0] dut_v,
                       input logic [CH-1:0] mdl_v, input logic [CH-1:0] exp);
        check(name, dut_v, exp);
        check({name, "_model"}, mdl_v, exp);
    endtask

    task automatic step(input logic [CH-1:0] bin, input logic r);
        logic [CH-1:0] tog;
        logic [CH-1:0] ns;
        int            idx;
        logic          s;
        btn_in = bin;
        rst    = r;
        @(posedge clk);
        if (r) begin
            hist[e] = '0;
            if (e > 0) hist[e-1] = '0;
            m_state = '0; m_pr = '0; m_rl = '0; m_lg = '0; m_rp = '0;
            for (int c = 0; c < CH; c++) run[c] = 0;
        end else begin
            hist[e] = bin;
            // A level is accepted when the last D synchronised samples
            // (raw samples delayed by two edges) all disagree with it.
            for (int c = 0; c < CH; c++) begin
                tog[c] = 1'b1;
                for (int k = 0; k < D; k++) begin
                    idx = e - 2 - k;
                    s   = (idx < 0) ? 1'b0 : hist[idx][c];
                    if (s == m_state[c]) tog[c] = 1'b0;
                end
                m_lg[c] = m_state[c] && (run[c] == L);
                m_rp[c] = m_state[c] && (run[c] > L) && ((run[c] - L) % R == 0);
            end
            ns   = m_state ^ tog;
            m_pr = tog & ns;
            m_rl = tog & ~ns;
            for (int c = 0; c < CH; c++)
                run[c] = ns[c] ? (m_state[c] ? run[c] + 1 : 1) : 0;
            m_state = ns;
        end
        e++;
        #1;
        check("state",    btn_state,    m_state);
        check("pressed",  btn_pressed,  m_pr);
        check("released", btn_released, m_rl);
        check("long",     btn_long,     m_lg);
        check("repeat",   btn_repeat,   REP_ON ? m_rp : '0);
    endtask

    task automatic run_n(input logic [CH-1:0] b, input int n);
        for (int i = 0; i < n; i++) step(b, 1'b0);
    endtask

    logic [CH-1:0] lvl;
    logic [CH-1:0] raw;
    int            dur [CH];
    int            age [CH];
    logic [CH-1:0] rep_exp;

    initial begin
        for (int i = 0; i < MAXE; i++) hist[i] = '0;
        m_state = '0; m_pr = '0; m_rl = '0; m_lg = '0; m_rp = '0;
        for (int c = 0; c < CH; c++) run[c] = 0;
        rep_exp = REP_ON ? 4'b0100 : 4'b0000;
        btn_in  = '0;
        rst     = 1'b1;

        // Reset state
        step('0, 1'b1);
        step('0, 1'b1);
        lit("rst_state", btn_state, m_state, 4'b0000);
        lit("rst_pressed", btn_pressed, m_pr, 4'b0000);

        // Clean press and release on ch0
        run_n(4'b0001, 9);
        lit("ch0_not_yet", btn_state, m_state, 4'b0000);
        run_n(4'b0001, 1);
        lit("ch0_state", btn_state, m_state, 4'b0001);
        lit("ch0_pressed", btn_pressed, m_pr, 4'b0001);
        run_n(4'b0001, 1);
        lit("ch0_pulse_1cyc", btn_pressed, m_pr, 4'b0000);
        run_n(4'b0000, 9);
        lit("ch0_still_held", btn_state, m_state, 4'b0001);
        run_n(4'b0000, 1);
        lit("ch0_released", btn_released, m_rl, 4'b0001);
        lit("ch0_state_low", btn_state, m_state, 4'b0000);

        // Bounce on ch1
        run_n(4'b0010, 5);
        run_n(4'b0000, 2);
        run_n(4'b0010, 9);
        lit("ch1_bounce_wait", btn_state, m_state, 4'b0000);
        run_n(4'b0010, 1);
        lit("ch1_bounce_press", btn_pressed, m_pr, 4'b0010);
        run_n(4'b0000, 12);

        // Long hold on ch2
        run_n(4'b0100, 9);
        lit("ch2_wait", btn_state, m_state, 4'b0000);
        run_n(4'b0100, 1);
        lit("ch2_pressed", btn_pressed, m_pr, 4'b0100);
        run_n(4'b0100, 31);
        lit("ch2_long_early", btn_long, m_lg, 4'b0000);
        run_n(4'b0100, 1);
        lit("ch2_long", btn_long, m_lg, 4'b0100);
        for (int k = 0; k < 3; k++) begin
            run_n(4'b0100, 7);
            check("ch2_rep_early", btn_repeat, 4'b0000);
            run_n(4'b0100, 1);
            check("ch2_repeat", btn_repeat, rep_exp);
        end
        run_n(4'b0100, 4);
        run_n(4'b0000, 12);

        // Simultaneous press on ch0 and ch3
        run_n(4'b1001, 9);
        lit("sim_wait", btn_state, m_state, 4'b0000);
        run_n(4'b1001, 1);
        lit("sim_pressed", btn_pressed, m_pr, 4'b1001);
        run_n(4'b0000, 12);

        // Reset while ch1 is held
        run_n(4'b0010, 10);
        lit("rst_ch1_pressed", btn_pressed, m_pr, 4'b0010);
        run_n(4'b0010, 20);
        step(4'b0010, 1'b1);
        lit("midrst_state", btn_state, m_state, 4'b0000);
        lit("midrst_long", btn_long, m_lg, 4'b0000);
        run_n(4'b0010, 9);
        lit("postrst_wait", btn_state, m_state, 4'b0000);
        run_n(4'b0010, 1);
        lit("postrst_pressed", btn_pressed, m_pr, 4'b0010);
        run_n(4'b0010, 31);
        lit("postrst_long_early", btn_long, m_lg, 4'b0000);
        run_n(4'b0010, 1);
        lit("postrst_long", btn_long, m_lg, 4'b0010);
        run_n(4'b0000, 12);

        // Randomized bouncy traffic with occasional resets
        lvl = '0;
        for (int c = 0; c < CH; c++) begin
            dur[c] = $urandom_range(1, 90);
            age[c] = 0;
        end
        for (int i = 0; i < 3000; i++) begin
            for (int c = 0; c < CH; c++) begin
                if (dur[c] == 0) begin
                    lvl[c] = ~lvl[c];
                    dur[c] = $urandom_range(1, 90);
                    age[c] = 0;
                end else begin
                    dur[c]--;
                    age[c]++;
                end
                raw[c] = lvl[c] ^ ((age[c] < 5) && ($urandom_range(0, 2) == 0));
            end
            step(raw, ($urandom_range(0, 599) == 0));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
